// File: rtl/prescaler_pkg.sv
// Shared definitions for the multi-channel timer prescaler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: clock-select codes, PSCR bit positions, writable-bit mask helper.
package prescaler_pkg;

   // Per-channel 3-bit clock-select codes
   typedef enum logic [2:0] {
      CS_STOP     = 3'd0,
      CS_CLK      = 3'd1,
      CS_DIV_A    = 3'd2,
      CS_DIV_B    = 3'd3,
      CS_DIV_C    = 3'd4,
      CS_DIV_D    = 3'd5,
      CS_EXT_FALL = 3'd6,
      CS_EXT_RISE = 3'd7
   } cs_t;

   localparam int PSCR_TSM = 7;

   // Bits of PSCR that hold state: TSM plus one PSR bit per channel.
   function automatic logic [7:0] pscr_mask(input int nch);
      logic [7:0] m;
      m = 8'h80;
      for (int i = 0; i < 7; i++)
         if (i < nch) m[i] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/prescaler_chan.sv
// One prescaler channel: divider counter, external-input synchroniser, select mux.
// Latency: tick registered one edge after the selected condition; external edges reach tick 3 edges after t changes.
// Backpressure: none; tick is a one-cycle clock enable the timer must consume.
// Ports: sys_clk/sys_rst clock and async reset, psr counter clear, cs clock select,
//        t raw external clock input, tick registered clock-enable pulse.
module prescaler_chan
   import prescaler_pkg::*;
#(
   parameter int CNT_W = 10,
   parameter int TAP2  = 3,
   parameter int TAP3  = 6,
   parameter int TAP4  = 8,
   parameter int TAP5  = 10
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       psr,
   input  logic [2:0] cs,
   input  logic       t,
   output logic       tick
);

   logic [CNT_W-1:0] cnt;
   logic             s1, s2, s3;
   logic             rise, fall;
   logic             sel;
   cs_t              cs_sel;

   assign cs_sel = cs_t'(cs);
   assign rise   = s2 & ~s3;
   assign fall   = ~s2 & s3;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt <= '0;
         s1  <= 1'b0;
         s2  <= 1'b0;
         s3  <= 1'b0;
      end else begin
         // Free-running; a cs change never disturbs the count, only PSR does.
         cnt <= psr ? '0 : cnt + 1'b1;
         s1  <= t;
         s2  <= s1;
         s3  <= s2;
      end
   end

   // A divide tap fires once per wrap of its low bits, i.e. when they are all ones.
   always_comb begin
      sel = 1'b0;
      case (cs_sel)
         CS_STOP:     sel = 1'b0;
         CS_CLK:      sel = 1'b1;
         CS_DIV_A:    sel = &cnt[TAP2-1:0];
         CS_DIV_B:    sel = &cnt[TAP3-1:0];
         CS_DIV_C:    sel = &cnt[TAP4-1:0];
         CS_DIV_D:    sel = &cnt[TAP5-1:0];
         CS_EXT_FALL: sel = fall;
         CS_EXT_RISE: sel = rise;
         default:     sel = 1'b0;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) tick <= 1'b0;
      else         tick <= sel;
   end

endmodule

// File: rtl/prescaler_mc.sv
// Multi-channel timer prescaler with IO-mapped control register PSCR.
// Latency: io_do one edge after the read strobe; PSCR writes effective at the next edge.
// Backpressure: none; IO accesses always complete in one cycle, ticks are fire-and-forget.
// Ports: sys_clk/sys_rst clock and async reset; io_a/io_we/io_re/io_di/io_do IO bus;
//        cs per-channel clock selects (3 bits each); t external clocks; tick clock enables.
module prescaler_mc
   import prescaler_pkg::*;
#(
   parameter logic [5:0] base_addr = 6'h10,
   parameter int         NCH       = 2,
   parameter int         CNT_W     = 10,
   parameter int         TAP2      = 3,
   parameter int         TAP3      = 6,
   parameter int         TAP4      = 8,
   parameter int         TAP5      = 10
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [5:0]       io_a,
   input  logic             io_we,
   input  logic             io_re,
   input  logic [7:0]       io_di,
   output logic [7:0]       io_do,
   input  logic [3*NCH-1:0] cs,
   input  logic [NCH-1:0]   t,
   output logic [NCH-1:0]   tick
);

   localparam logic [7:0] WR_MASK = pscr_mask(NCH);

   logic [7:0] pscr;
   logic       wr_en, rd_en;

   assign wr_en = io_we && (io_a == base_addr);
   assign rd_en = io_re && (io_a == base_addr);

   // Unimplemented bits are masked on write so they always read back 0.
   // With TSM clear, PSR bits live for exactly one cycle; TSM=0 also means
   // every other bit is already 0, so clearing the whole register is enough.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)                pscr <= 8'h00;
      else if (wr_en)             pscr <= io_di & WR_MASK;
      else if (!pscr[PSCR_TSM])   pscr <= 8'h00;
   end

   // Drives 0 when not addressed so several peripherals can be OR-ed together.
   // A same-cycle write and read returns the pre-write value.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)    io_do <= 8'h00;
      else if (rd_en) io_do <= pscr;
      else            io_do <= 8'h00;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      prescaler_chan #(
         .CNT_W (CNT_W),
         .TAP2  (TAP2),
         .TAP3  (TAP3),
         .TAP4  (TAP4),
         .TAP5  (TAP5)
      ) u_chan (
         .sys_clk (sys_clk),
         .sys_rst (sys_rst),
         .psr     (pscr[i]),
         .cs      (cs[3*i +: 3]),
         .t       (t[i]),
         .tick    (tick[i])
      );
   end

endmodule

// File: tb/tb_prescaler_mc.sv
// Self-checking bench for prescaler_mc (NCH=2, default taps).
// Expected tick cycle numbers are pushed when stimulus is applied and compared
// against tick cycles recorded from the DUT.
module tb_prescaler_mc;

   localparam logic [5:0] BASE = 6'h10;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [5:0] io_a    = 6'h00;
   logic       io_we   = 1'b0;
   logic       io_re   = 1'b0;
   logic [7:0] io_di   = 8'h00;
   logic [7:0] io_do;
   logic [5:0] cs      = 6'h00;
   logic [1:0] t       = 2'b00;
   logic [1:0] tick;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int win_start = 1 << 30;
   int exp0[$], exp1[$], obs0[$], obs1[$];

   prescaler_mc #(
      .base_addr (BASE),
      .NCH       (2),
      .CNT_W     (10),
      .TAP2      (3),
      .TAP3      (6),
      .TAP4      (8),
      .TAP5      (10)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .io_a    (io_a),
      .io_we   (io_we),
      .io_re   (io_re),
      .io_di   (io_di),
      .io_do   (io_do),
      .cs      (cs),
      .t       (t),
      .tick    (tick)
   );

   always #5 sys_clk = ~sys_clk;

   // cyc = index of the most recent rising edge
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Tick recorder: a tick seen at a falling edge was registered at rising edge cyc
   always @(negedge sys_clk) begin
      if (cyc >= win_start) begin
         if (tick[0]) obs0.push_back(cyc);
         if (tick[1]) obs1.push_back(cyc);
      end
   end

   task automatic new_window(input int start);
      win_start = start;
      obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge sys_clk);
   endtask

   // Returns the rising edge on which the write took effect
   task automatic io_write(input logic [7:0] d, output int edge_n);
      @(negedge sys_clk);
      io_a = BASE; io_we = 1'b1; io_di = d;
      @(negedge sys_clk);
      edge_n = cyc;
      io_we = 1'b0; io_a = 6'h00; io_di = 8'h00;
   endtask

   task automatic io_read(input logic [5:0] a, output logic [7:0] d);
      @(negedge sys_clk);
      io_a = a; io_re = 1'b1;
      @(negedge sys_clk);
      d = io_do;
      io_re = 1'b0; io_a = 6'h00;
   endtask

   task automatic test_reset;
      logic [7:0] d;
      total++;
      if (io_do !== 8'h00) begin bad++; $display("FAIL reset_io_do got %h exp 00", io_do); end
      for (int v = 0; v < 8; v++) begin
         cs = {v[2:0], v[2:0]};
         @(negedge sys_clk);
         total++;
         if (tick !== 2'b00) begin bad++; $display("FAIL reset_tick cs=%0d got %b exp 00", v, tick); end
      end
      cs = 6'h00;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      io_read(BASE, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL reset_read got %h exp 00", d); end
   endtask

   task automatic test_rw;
      logic [7:0] d;
      int e;
      io_write(8'hFF, e);
      io_read(BASE, d);
      total++;
      if (d !== 8'h83) begin bad++; $display("FAIL rw_mask got %h exp 83", d); end
      io_read(6'h11, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL rw_other_addr got %h exp 00", d); end
      @(negedge sys_clk);
      io_a = BASE; io_we = 1'b1; io_re = 1'b1; io_di = 8'h00;
      @(negedge sys_clk);
      io_we = 1'b0; io_re = 1'b0; io_a = 6'h00;
      total++;
      if (io_do !== 8'h83) begin bad++; $display("FAIL rw_we_re got %h exp 83", io_do); end
      io_read(BASE, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL rw_cleared got %h exp 00", d); end
   endtask

   task automatic test_div;
      int e, x, o;
      cs = {3'd0, 3'd2};
      io_write(8'h01, e);               // PSR0 strobe: counter 0 is 0 after edge e+1
      new_window(e + 2);
      for (int m = 0; m < 8; m++) exp0.push_back(e + 9 + 8 * m);
      wait_until(e + 68);
      while (exp0.size() > 0) begin
         x = exp0.pop_front(); total++;
         if (obs0.size() == 0) begin bad++; $display("FAIL div8_tick got none exp cyc %0d", x); end
         else begin
            o = obs0.pop_front();
            if (o !== x) begin bad++; $display("FAIL div8_tick got cyc %0d exp cyc %0d", o, x); end
         end
      end
      total++;
      if (obs0.size() + obs1.size() != 0) begin
         bad++; $display("FAIL div8_extra got %0d extra ticks exp 0", obs0.size() + obs1.size());
      end
      // Switch to /1024 without resetting the count
      cs = {3'd0, 3'd5};
      new_window(cyc + 1);
      exp0.push_back(e + 1025);
      exp0.push_back(e + 2049);
      wait_until(e + 2060);
      while (exp0.size() > 0) begin
         x = exp0.pop_front(); total++;
         if (obs0.size() == 0) begin bad++; $display("FAIL div1024_tick got none exp cyc %0d", x); end
         else begin
            o = obs0.pop_front();
            if (o !== x) begin bad++; $display("FAIL div1024_tick got cyc %0d exp cyc %0d", o, x); end
         end
      end
      total++;
      if (obs0.size() != 0) begin bad++; $display("FAIL div1024_extra got %0d exp 0", obs0.size()); end
   endtask

   task automatic test_tsm;
      int s, e1, e2, x, o;
      logic [7:0] d;
      cs = {3'd3, 3'd3};
      io_write(8'h02, s);               // align channel 1: counter 0 after edge s+1
      io_write(8'h81, e1);              // hold PSR0
      new_window(e1 + 2);
      exp1.push_back(s + 65);
      exp1.push_back(s + 129);
      exp1.push_back(s + 193);
      io_read(BASE, d);
      total++;
      if (d !== 8'h81) begin bad++; $display("FAIL tsm_hold_read got %h exp 81", d); end
      wait_until(s + 200);
      while (exp1.size() > 0) begin
         x = exp1.pop_front(); total++;
         if (obs1.size() == 0) begin bad++; $display("FAIL tsm_ch1_tick got none exp cyc %0d", x); end
         else begin
            o = obs1.pop_front();
            if (o !== x) begin bad++; $display("FAIL tsm_ch1_tick got cyc %0d exp cyc %0d", o, x); end
         end
      end
      total++;
      if (obs0.size() != 0) begin bad++; $display("FAIL tsm_ch0_held got %0d ticks exp 0", obs0.size()); end
      io_write(8'h00, e2);
      new_window(e2 + 1);
      exp0.push_back(e2 + 64);
      wait_until(e2 + 70);
      while (exp0.size() > 0) begin
         x = exp0.pop_front(); total++;
         if (obs0.size() == 0) begin bad++; $display("FAIL tsm_release got none exp cyc %0d", x); end
         else begin
            o = obs0.pop_front();
            if (o !== x) begin bad++; $display("FAIL tsm_release got cyc %0d exp cyc %0d", o, x); end
         end
      end
      total++;
      if (obs0.size() != 0) begin bad++; $display("FAIL tsm_release_extra got %0d exp 0", obs0.size()); end
   endtask

   task automatic test_align;
      int e, x, o;
      logic [7:0] d;
      io_write(8'h03, e);
      io_read(BASE, d);                 // captured at edge e+2
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL align_autoclear got %h exp 00", d); end
      new_window(e + 3);
      exp0.push_back(e + 65); exp0.push_back(e + 129);
      exp1.push_back(e + 65); exp1.push_back(e + 129);
      wait_until(e + 135);
      while (exp0.size() > 0) begin
         x = exp0.pop_front(); total++;
         if (obs0.size() == 0) begin bad++; $display("FAIL align_ch0 got none exp cyc %0d", x); end
         else begin
            o = obs0.pop_front();
            if (o !== x) begin bad++; $display("FAIL align_ch0 got cyc %0d exp cyc %0d", o, x); end
         end
      end
      while (exp1.size() > 0) begin
         x = exp1.pop_front(); total++;
         if (obs1.size() == 0) begin bad++; $display("FAIL align_ch1 got none exp cyc %0d", x); end
         else begin
            o = obs1.pop_front();
            if (o !== x) begin bad++; $display("FAIL align_ch1 got cyc %0d exp cyc %0d", o, x); end
         end
      end
   endtask

   task automatic test_ext;
      int c, x, o;
      cs = {3'd7, 3'd0};
      t  = 2'b00;
      repeat (5) @(negedge sys_clk);
      c = cyc;
      new_window(c + 1);
      t[1] = 1'b1;                      // meets setup before edge c+1
      exp1.push_back(c + 3);
      wait_until(c + 10);               // held high well over 5 cycles
      while (exp1.size() > 0) begin
         x = exp1.pop_front(); total++;
         if (obs1.size() == 0) begin bad++; $display("FAIL ext_rise got none exp cyc %0d", x); end
         else begin
            o = obs1.pop_front();
            if (o !== x) begin bad++; $display("FAIL ext_rise got cyc %0d exp cyc %0d", o, x); end
         end
      end
      total++;
      if (obs1.size() != 0) begin bad++; $display("FAIL ext_rise_extra got %0d exp 0", obs1.size()); end
      cs = {3'd6, 3'd0};
      repeat (3) @(negedge sys_clk);
      c = cyc;
      new_window(c + 1);
      t[1] = 1'b0;
      exp1.push_back(c + 3);
      wait_until(c + 10);
      while (exp1.size() > 0) begin
         x = exp1.pop_front(); total++;
         if (obs1.size() == 0) begin bad++; $display("FAIL ext_fall got none exp cyc %0d", x); end
         else begin
            o = obs1.pop_front();
            if (o !== x) begin bad++; $display("FAIL ext_fall got cyc %0d exp cyc %0d", o, x); end
         end
      end
      total++;
      if (obs1.size() != 0) begin bad++; $display("FAIL ext_fall_extra got %0d exp 0", obs1.size()); end
      // Half-cycle glitch straddling a rising edge
      cs = {3'd7, 3'd0};
      repeat (4) @(negedge sys_clk);
      new_window(cyc + 1);
      @(negedge sys_clk);
      #2 t[1] = 1'b1;
      #5 t[1] = 1'b0;
      repeat (8) @(negedge sys_clk);
      total++;
      if (obs1.size() > 1) begin bad++; $display("FAIL ext_glitch_edge got %0d pulses exp <=1", obs1.size()); end
      // Short glitch between rising edges
      new_window(cyc + 1);
      @(negedge sys_clk);
      #1 t[1] = 1'b1;
      #3 t[1] = 1'b0;
      repeat (8) @(negedge sys_clk);
      total++;
      if (obs1.size() > 1) begin bad++; $display("FAIL ext_glitch_mid got %0d pulses exp <=1", obs1.size()); end
   endtask

   task automatic test_rst;
      int e, r, x, o;
      logic [7:0] d;
      cs = {3'd0, 3'd1};
      io_write(8'h80, e);
      @(negedge sys_clk);
      io_a = BASE; io_re = 1'b1;
      @(negedge sys_clk);
      total++;
      if (tick[0] !== 1'b1) begin bad++; $display("FAIL rst_pre_tick got %b exp 1", tick[0]); end
      total++;
      if (io_do !== 8'h80) begin bad++; $display("FAIL rst_pre_io_do got %h exp 80", io_do); end
      #2 sys_rst = 1'b1;
      #1;
      total++;
      if (tick !== 2'b00) begin bad++; $display("FAIL rst_async_tick got %b exp 00", tick); end
      total++;
      if (io_do !== 8'h00) begin bad++; $display("FAIL rst_async_io_do got %h exp 00", io_do); end
      io_re = 1'b0; io_a = 6'h00;
      cs = {3'd0, 3'd2};
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      r = cyc;                          // first counting edge is r+1
      new_window(r + 1);
      exp0.push_back(r + 8);
      exp0.push_back(r + 16);
      wait_until(r + 20);
      while (exp0.size() > 0) begin
         x = exp0.pop_front(); total++;
         if (obs0.size() == 0) begin bad++; $display("FAIL rst_restart got none exp cyc %0d", x); end
         else begin
            o = obs0.pop_front();
            if (o !== x) begin bad++; $display("FAIL rst_restart got cyc %0d exp cyc %0d", o, x); end
         end
      end
      io_read(BASE, d);
      total++;
      if (d !== 8'h00) begin bad++; $display("FAIL rst_pscr got %h exp 00", d); end
   endtask

   initial begin
      test_reset;
      test_rw;
      test_div;
      test_tsm;
      test_align;
      test_ext;
      test_rst;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
